// File: rtl/alu_md_unit_pkg.sv
// Shared defines for the EX stage: ALU control codes, multiply/divide op codes and the
// default multi-cycle latencies. Also used by the ALU-control decoder.
package alu_md_unit_pkg;

  typedef enum logic [3:0] {
    AluZero = 4'b0000,
    AluOr   = 4'b0001,
    AluAdd  = 4'b0010,
    AluSub  = 4'b0110
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    MdNone  = 3'b000,
    MdMult  = 3'b001,
    MdMultu = 3'b010,
    MdDiv   = 3'b011,
    MdDivu  = 3'b100,
    MdMthi  = 3'b101,
    MdMtlo  = 3'b110,
    MdRsvd  = 3'b111
  } md_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } md_state_e;

  localparam int unsigned MulCycDefault = 5;
  localparam int unsigned DivCycDefault = 10;

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU: add, sub, or; every other control code yields zero.
module alu32
  import alu_md_unit_pkg::*;
(
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = 32'h0;
    case (alu_ctrl_e'(ctrl_i))
      AluAdd:  result_o = a_i + b_i;
      AluSub:  result_o = a_i - b_i;
      AluOr:   result_o = a_i | b_i;
      default: result_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage ALU plus HI/LO multiply/divide engine. The result is computed at issue and
// held in pending registers; it is committed to HI/LO when the latency counter expires.
module alu_md_unit
  import alu_md_unit_pkg::*;
#(
  parameter int unsigned MUL_CYC = MulCycDefault,
  parameter int unsigned DIV_CYC = DivCycDefault
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  aluCtrl,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [2:0]  md_op,
  input  logic        md_start,
  output logic [31:0] aluResult,
  output logic        md_busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MulCnt = 4'(MUL_CYC);
  localparam logic [3:0] DivCnt = 4'(DIV_CYC);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  alu32 u_alu32 (
    .ctrl_i   (aluCtrl),
    .a_i      (srcA),
    .b_i      (srcB),
    .result_o (aluResult)
  );

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] a_s, b_s, quo_s, rem_s;
  logic [31:0]        b_u, quo_u, rem_u;

  // Sign-extended operands make the low 64 bits of an unsigned product the signed product.
  assign prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign prod_u = {32'h0, srcA} * {32'h0, srcB};

  // Divisor forced to 1 on zero so the datapath stays defined; the result is discarded.
  assign a_s   = $signed(srcA);
  assign b_s   = (srcB == 32'h0) ? 32'sd1 : $signed(srcB);
  assign quo_s = a_s / b_s;
  assign rem_s = a_s % b_s;
  assign b_u   = (srcB == 32'h0) ? 32'd1 : srcB;
  assign quo_u = srcA / b_u;
  assign rem_u = srcA % b_u;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      StIdle: begin
        if (md_start) begin
          case (md_op_e'(md_op))
            MdMult: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MulCnt;
              state_d   = StBusy;
            end
            MdMultu: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MulCnt;
              state_d   = StBusy;
            end
            MdDiv: begin
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
              pend_wr_d = (srcB != 32'h0);
              cnt_d     = DivCnt;
              state_d   = StBusy;
            end
            MdDivu: begin
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
              pend_wr_d = (srcB != 32'h0);
              cnt_d     = DivCnt;
              state_d   = StBusy;
            end
            MdMthi:  hi_d = srcA;
            MdMtlo:  lo_d = srcA;
            default: ;
          endcase
        end
      end
      StBusy: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = StIdle;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    md_busy = (state_q == StBusy);
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: a behavioural HI/LO model checked every cycle, plus
// hand-computed literal expectations for the key vectors.
module tb_alu_md_unit;

  localparam int unsigned MulCyc = 5;
  localparam int unsigned DivCyc = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  aluCtrl = 4'b0000;
  logic [31:0] srcA = 32'h0;
  logic [31:0] srcB = 32'h0;
  logic [2:0]  md_op = 3'b000;
  logic        md_start = 1'b0;
  logic [31:0] aluResult, hi, lo;
  logic        md_busy;

  int n_checks = 0;
  int n_fail = 0;

  alu_md_unit #(
    .MUL_CYC (MulCyc),
    .DIV_CYC (DivCyc)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .aluCtrl   (aluCtrl),
    .srcA      (srcA),
    .srcB      (srcB),
    .md_op     (md_op),
    .md_start  (md_start),
    .aluResult (aluResult),
    .md_busy   (md_busy),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] alu_model(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
    if (c == 4'b0010) return a + b;
    if (c == 4'b0110) return a + ~b + 32'd1;
    if (c == 4'b0001) return a | b;
    return 32'h0;
  endfunction

  // Returns {hi, lo} for a multiply using 64-bit integer arithmetic.
  function automatic logic [63:0] mul_model(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint x, y;
    x = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    y = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    return 64'(x * y);
  endfunction

  // Returns {remainder, quotient} from magnitudes, truncating toward zero.
  function automatic logic [63:0] div_model(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
    longint x, y, q, r, ax, ay;
    x  = sgn ? longint'($signed(a)) : longint'({32'h0, a});
    y  = sgn ? longint'($signed(b)) : longint'({32'h0, b});
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    q  = ax / ay;
    if ((x < 0) != (y < 0)) q = -q;
    r  = x - q * y;
    return {r[31:0], q[31:0]};
  endfunction

  logic [31:0] m_hi = 32'h0, m_lo = 32'h0, m_phi = 32'h0, m_plo = 32'h0;
  logic        m_wr = 1'b0;
  int          m_left = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= 32'h0; m_lo <= 32'h0; m_phi <= 32'h0; m_plo <= 32'h0;
      m_wr <= 1'b0; m_left <= 0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1 && m_wr) begin
        m_hi <= m_phi;
        m_lo <= m_plo;
      end
    end else if (md_start) begin
      case (md_op)
        3'b001, 3'b010: begin
          {m_phi, m_plo} <= mul_model(md_op == 3'b001, srcA, srcB);
          m_wr <= 1'b1;
          m_left <= MulCyc;
        end
        3'b011, 3'b100: begin
          if (srcB != 32'h0) {m_phi, m_plo} <= div_model(md_op == 3'b011, srcA, srcB);
          m_wr <= (srcB != 32'h0);
          m_left <= DivCyc;
        end
        3'b101: m_hi <= srcA;
        3'b110: m_lo <= srcA;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    check("model_busy", {31'h0, md_busy}, {31'h0, m_left > 0});
    check("model_hi", hi, m_hi);
    check("model_lo", lo, m_lo);
    check("model_alu", aluResult, alu_model(aluCtrl, srcA, srcB));
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    md_start = 1'b1; md_op = op; srcA = a; srcB = b;
    @(posedge clk); #2;
    md_start = 1'b0; md_op = 3'b000;
  endtask

  task automatic wait_idle(output int busy_cycles);
    busy_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!md_busy) return;
      busy_cycles++;
    end
    check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  int nb;

  initial begin
    // Reset held with an mthi already presented: it must take effect on the first edge.
    md_start = 1'b1; md_op = 3'b101; srcA = 32'h55;
    @(negedge clk);
    check("reset_busy", {31'h0, md_busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    @(negedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    md_start = 1'b0; md_op = 3'b000;
    @(negedge clk);
    check("first_edge_mthi", hi, 32'h55);

    aluCtrl = 4'b0110; srcA = 32'd5; srcB = 32'd7; #1;
    check("alu_sub", aluResult, 32'hFFFFFFFE);
    aluCtrl = 4'b1111; #1;
    check("alu_other", aluResult, 32'h0);
    aluCtrl = 4'b0010; srcA = 32'hFFFFFFFF; srcB = 32'd1; #1;
    check("alu_add_wrap", aluResult, 32'h0);
    aluCtrl = 4'b0001; srcA = 32'h0000F0F0; srcB = 32'h00000F0F; #1;
    check("alu_or", aluResult, 32'h0000FFFF);
    aluCtrl = 4'b0000; #1;
    check("alu_zero", aluResult, 32'h0);

    issue(3'b001, 32'hFFFFFFFF, 32'd2);
    wait_idle(nb);
    check("mult_busy_cycles", nb, 32'd5);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFE);

    issue(3'b010, 32'hFFFFFFFF, 32'd2);
    wait_idle(nb);
    check("multu_hi", hi, 32'h1);
    check("multu_lo", lo, 32'hFFFFFFFE);

    issue(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_idle(nb);
    check("div_busy_cycles", nb, 32'd10);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(3'b100, 32'd100, 32'd7);
    wait_idle(nb);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(3'b101, 32'h11, 32'h0);
    issue(3'b110, 32'h22, 32'h0);
    issue(3'b000, 32'h77, 32'h0);
    issue(3'b111, 32'h78, 32'h0);
    @(negedge clk);
    check("mthi_hi", hi, 32'h11);
    check("mtlo_lo", lo, 32'h22);
    issue(3'b100, 32'd1234, 32'd0);
    wait_idle(nb);
    check("div0_busy_cycles", nb, 32'd10);
    check("div0_hi", hi, 32'h11);
    check("div0_lo", lo, 32'h22);

    issue(3'b001, 32'd3, 32'd4);
    @(negedge clk);
    @(negedge clk);
    issue(3'b110, 32'd9, 32'd0);
    wait_idle(nb);
    check("mtlo_ignored_lo", lo, 32'd12);
    check("mtlo_ignored_hi", hi, 32'd0);

    issue(3'b011, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); #2;
    reset = 1'b0; #1;
    check("abort_busy", {31'h0, md_busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("abort_no_commit_hi", hi, 32'h0);
    check("abort_no_commit_lo", lo, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
